// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pac-Man game core front end.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FROZEN = 2'b10
    } sched_state_t;

    localparam int WIDTH        = 28;
    localparam int HEIGHT       = 31;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_TICK_DIV = 4;

    // A divide-by-one counter still needs one bit to exist.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Direction command FIFO: DEPTH x dir_t, push/pop/flush, combinational head.
module move_fifo
    import pacman_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [1:0]               i_din,
    output logic [1:0]               o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    dir_t           r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_level;
    logic           w_push;
    logic           w_pop;

    // Flush wins over everything so a freeze never leaves stale entries.
    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= dir_t'(i_din);
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_level = r_level;

endmodule

// File: rtl/pacman_move_sched.sv
// Buffers direction commands and issues one per game tick; freezes on catch.
// Optional feature macro: PACMAN_AUTO_REPEAT_EN (repeat last move on empty tick).
module pacman_move_sched
    import pacman_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_dir,
    output logic                    cmd_ready,
    input  logic                    start,
    input  logic                    catch,
    output logic [1:0]              pacman_move,
    output logic                    move_stb,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [1:0]              game_state
);

    localparam int             CW       = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    sched_state_t  r_state;
    sched_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_move;
    logic          r_stb;
    logic          w_tick;
    logic          w_freeze;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_empty;
    logic          w_full;
    logic [1:0]    w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        case (r_state)
            IDLE: begin
                if (catch) begin
                    w_state_nxt = FROZEN;
                    w_freeze    = 1'b1;
                end else if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (catch) begin
                    w_state_nxt = FROZEN;
                    w_freeze    = 1'b1;
                end
            end
            FROZEN:  w_state_nxt = FROZEN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_tick    = (r_state == RUN) && (r_cnt == CNT_LAST);
    assign w_pop     = w_tick && !catch && !w_empty;
    assign cmd_ready = (r_state != FROZEN) && !w_full;
    assign w_push    = cmd_valid && cmd_ready;

`ifdef PACMAN_AUTO_REPEAT_EN
    assign w_issue = w_tick && !catch;
`else
    assign w_issue = w_pop;
`endif

    // Held at zero outside RUN, which also gives the clear on RUN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_cnt <= '0;
        else if (r_state != RUN)    r_cnt <= '0;
        else if (r_cnt == CNT_LAST) r_cnt <= '0;
        else                        r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_move <= 2'b00;
            r_stb  <= 1'b0;
        end else begin
            r_stb <= w_issue;
            if (w_pop) r_move <= w_head;
        end
    end

    move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_freeze),
        .i_din   (cmd_dir),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (fifo_level)
    );

    assign pacman_move = r_move;
    assign move_stb    = r_stb;
    assign game_state  = r_state;

endmodule

// File: tb/tb_pacman_move_sched.sv
// Bench for pacman_move_sched: directed scenarios plus random traffic vs a queue model.
`timescale 1ns/1ps
module tb_pacman_move_sched;

    localparam int DEPTH = 4;
`ifdef PACMAN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic       start = 1'b0;
    logic       catch = 1'b0;

    logic       rdy_a, stb_a, rdy_b, stb_b;
    logic [1:0] mv_a, gs_a, mv_b, gs_b;
    logic [2:0] lvl_a, lvl_b;

    always #5 clk = ~clk;

    pacman_move_sched #(.DEPTH(DEPTH), .TICK_DIV(4)) u_dut_div4 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy_a), .start(start), .catch(catch), .pacman_move(mv_a),
        .move_stb(stb_a), .fifo_level(lvl_a), .game_state(gs_a)
    );

    pacman_move_sched #(.DEPTH(DEPTH), .TICK_DIV(1)) u_dut_div1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_ready(rdy_b), .start(start), .catch(catch), .pacman_move(mv_b),
        .move_stb(stb_b), .fifo_level(lvl_b), .game_state(gs_b)
    );

    // Only one instance is scored at a time; the model follows that one.
    bit         sel_b = 1'b0;
    logic       o_rdy, o_stb;
    logic [1:0] o_move, o_gs;
    logic [2:0] o_lvl;
    always_comb begin
        o_rdy  = sel_b ? rdy_b : rdy_a;
        o_stb  = sel_b ? stb_b : stb_a;
        o_move = sel_b ? mv_b  : mv_a;
        o_gs   = sel_b ? gs_b  : gs_a;
        o_lvl  = sel_b ? lvl_b : lvl_a;
    end

    int n_vec = 0;
    int n_err = 0;

    // Behavioural reference: state number, command queue, tick phase, output.
    int         m_div = 4;
    int         m_state;
    logic [1:0] q[$];
    int         m_cnt;
    logic [1:0] m_move;
    logic       m_stb;
    logic [1:0] seen[$];

    function automatic void model_reset();
        m_state = 0;
        q.delete();
        m_cnt  = 0;
        m_move = 2'b00;
        m_stb  = 1'b0;
    endfunction

    function automatic bit model_ready();
        return (m_state != 2) && (q.size() < DEPTH);
    endfunction

    function automatic void model_step();
        bit acc, tick;
        acc   = cmd_valid && model_ready();
        tick  = (m_state == 1) && (m_cnt == m_div - 1);
        m_stb = 1'b0;
        if (m_state != 2 && catch) begin
            m_state = 2;
            q.delete();
            return;
        end
        if (tick) begin
            if (q.size() > 0) begin
                m_move = q.pop_front();
                m_stb  = 1'b1;
            end else if (AUTO) begin
                m_stb = 1'b1;
            end
        end
        if (acc) q.push_back(cmd_dir);
        if (m_state == 1) m_cnt = (m_cnt + 1) % m_div;
        else if (m_state == 0 && start) begin
            m_state = 1;
            m_cnt   = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"}, 8'(o_gs),   8'(m_state));
        check({tag, ".move"},  8'(o_move), 8'(m_move));
        check({tag, ".stb"},   8'(o_stb),  8'(m_stb));
        check({tag, ".level"}, 8'(o_lvl),  8'(q.size()));
        check({tag, ".ready"}, 8'(o_rdy),  8'(model_ready()));
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic s, input logic c);
        cmd_valid = v;
        cmd_dir   = d;
        start     = s;
        catch     = c;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        if (o_stb === 1'b1) seen.push_back(o_move);
    endtask

    // Reset asserted between edges; the outputs must change with no clock.
    task automatic do_reset();
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.state", 8'(o_gs),   8'd0);
        check("rst.level", 8'(o_lvl),  8'd0);
        check("rst.stb",   8'(o_stb),  8'd0);
        check("rst.move",  8'(o_move), 8'd0);
        check("rst.ready", 8'(o_rdy),  8'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_chunk(input int n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0);
            cycle("rand");
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [1:0] cmds[5];
        int first_rdy, got5, nstb, bound;
        bit acc;

        cmds[0] = 2'b00; cmds[1] = 2'b01; cmds[2] = 2'b11; cmds[3] = 2'b01; cmds[4] = 2'b10;

        // Preload UP,RIGHT,RIGHT then start: strobes sampled at E+5, E+9, E+13.
        do_reset();
        drive(1'b1, 2'b00, 1'b0, 1'b0); cycle("t2.pre");
        drive(1'b1, 2'b11, 1'b0, 1'b0); cycle("t2.pre");
        drive(1'b1, 2'b11, 1'b0, 1'b0); cycle("t2.pre");
        drive(1'b0, 2'b00, 1'b1, 1'b0); cycle("t2.start");
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        for (int j = 1; j <= 14; j++) begin
            cycle("t2");
            check("t2.stb_time", 8'(o_stb), 8'((j + 1 == 5) || (j + 1 == 9) || (j + 1 == 13)));
            check("t2.move_seq", 8'(o_move), (j + 1 >= 9) ? 8'd3 : 8'd0);
            check("t2.level_seq", 8'(o_lvl), (j + 1 < 5) ? 8'd3 : (j + 1 < 9) ? 8'd2 : (j + 1 < 13) ? 8'd1 : 8'd0);
        end

        // Full FIFO back-pressure; fifth command waits for the first pop.
        do_reset();
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, cmds[i], 1'b0, 1'b0);
            cycle("t3.fill");
        end
        check("t3.ready_full", 8'(o_rdy), 8'd0);
        drive(1'b1, cmds[4], 1'b1, 1'b0);
        cycle("t3.start");
        start     = 1'b0;
        first_rdy = -1;
        got5      = 0;
        for (int j = 1; j <= 24; j++) begin
            cmd_valid = (got5 == 0);
            acc = cmd_valid && model_ready();
            cycle("t3");
            if (acc) got5 = 1;
            if (first_rdy < 0 && o_rdy === 1'b1) first_rdy = j;
        end
        check("t3.accepted5", 8'(got5), 8'd1);
        check("t3.first_ready", 8'(first_rdy), 8'd4);
        check("t3.n_issued", 8'(seen.size()), 8'd5);
        for (int i = 0; i < 5; i++)
            check("t3.order", (i < seen.size()) ? 8'(seen[i]) : 8'hff, 8'(cmds[i]));

        // Reset mid-RUN with three entries buffered.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i + 1), 1'b0, 1'b0);
            cycle("t1.fill");
        end
        drive(1'b0, 2'b00, 1'b1, 1'b0); cycle("t1.start");
        drive(1'b0, 2'b00, 1'b0, 1'b0); cycle("t1.run");
        check("t1.level3", 8'(o_lvl), 8'd3);
        check("t1.run", 8'(o_gs), 8'd1);
        do_reset();

        // Catch on a tick cycle with two entries: no pop, no strobe, flush.
        drive(1'b1, 2'b11, 1'b0, 1'b0); cycle("t4.fill");
        drive(1'b1, 2'b01, 1'b0, 1'b0); cycle("t4.fill");
        drive(1'b0, 2'b00, 1'b1, 1'b0); cycle("t4.start");
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        bound = 0;
        while (!(m_state == 1 && m_cnt == m_div - 1) && bound < 10) begin
            cycle("t4.wait");
            bound++;
        end
        check("t4.reached_tick", 8'(bound < 10), 8'd1);
        check("t4.level2", 8'(o_lvl), 8'd2);
        drive(1'b1, 2'b10, 1'b0, 1'b1); cycle("t4.catch");
        check("t4.frozen", 8'(o_gs), 8'd2);
        check("t4.flushed", 8'(o_lvl), 8'd0);
        check("t4.no_stb", 8'(o_stb), 8'd0);
        check("t4.ready0", 8'(o_rdy), 8'd0);
        check("t4.move_hold", 8'(o_move), 8'd0);
        drive(1'b1, 2'b10, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) cycle("t4.start_ignored");
        check("t4.still_frozen", 8'(o_gs), 8'd2);

        // Empty FIFO after a LEFT move: repeat or hold depending on build.
        do_reset();
        drive(1'b1, 2'b10, 1'b0, 1'b0); cycle("t5.fill");
        drive(1'b0, 2'b00, 1'b1, 1'b0); cycle("t5.start");
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        nstb = 0;
        for (int j = 1; j <= 20; j++) begin
            cycle("t5");
            if (o_stb === 1'b1) nstb++;
        end
        check("t5.n_strobes", 8'(nstb), AUTO ? 8'd5 : 8'd1);
        check("t5.move_left", 8'(o_move), 8'd2);

        for (int k = 0; k < 5; k++) rand_chunk(60);

        // Divide-by-one instance: one strobe per cycle, level balanced.
        sel_b = 1'b1;
        m_div = 1;
        do_reset();
        drive(1'b1, 2'b01, 1'b0, 1'b0); cycle("t6.fill");
        drive(1'b1, 2'b10, 1'b0, 1'b0); cycle("t6.fill");
        drive(1'b0, 2'b00, 1'b1, 1'b0); cycle("t6.start");
        for (int j = 1; j <= 8; j++) begin
            drive(1'b1, 2'(j), 1'b0, 1'b0);
            cycle("t6");
            check("t6.stb_every", 8'(o_stb), 8'd1);
            check("t6.level_hold", 8'(o_lvl), 8'd2);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) rand_chunk(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
